multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multicycle control sequencer for the 16-bit core. It consumes the decoded OpCode/FuncCode fields from the instruction decoder and drives the datapath enables and muxes one phase per state: fetch, decode, execute, memory, writeback.
- It owns the instruction/data memory request handshake, including a timeout.
- It keeps a retired-instruction counter.

Parameters:
- TIMEOUT_W, 4, width of the memory-wait timeout counter; timeout fires after 2**TIMEOUT_W-1 wait cycles.
- ICNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  5  decoded OpCode (Instruction[15:11]).
- func  in  3  decoded FuncCode (Instruction[2:0]).
- zero  in  1  ALU zero flag from the EXEC compare.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write strobe; qualified by mem_req.
- iord  out  1  0 = PC address, 1 = ALU-result address.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = JTarget.
- alu_op  out  3  ALU function.
- alu_src_b  out  2  0 = reg, 1 = constant 1, 2 = sign-extended Imm.
- reg_write  out  1  register-file write enable.
- wb_src  out  2  0 = ALU, 1 = memory data, 2 = PC (link).
- reg_dst  out  1  0 = ReadReg3 field, 1 = ReadReg2 field; link writes r15 via wb_src=2.
- halted  out  1  core stopped.
- illegal  out  1  sticky, set on an undefined opcode.
- bus_error  out  1  sticky, set on a memory timeout.
- icount  out  ICNT_W  retired-instruction count.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset value: every output is 0 and the state is FETCH. mem_req rises the first cycle after reset deasserts.
- Output encoding: outputs are Moore, decoded from the state register plus the registered opcode/func. pc_write, ir_write and reg_write are single-cycle pulses.
- Opcode map, opcode[4]=1 (R-type): alu_op=func, writeback to ReadReg3.
- Opcode map, opcode[4]=0:
  - 00000 LW
  - 00001 SW
  - 00010 ADDI
  - 00011 BEQ
  - 00100 BNE
  - 00101 J
  - 00110 JAL
  - 00111 HALT
  - 01000-01111 illegal
- FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_src=0, alu_src_b=1, alu_op=ADD; go to DECODE.
- DECODE: latch opcode/func. Illegal opcode: set illegal, go to HALT. HALT opcode: go to HALT (icount increments). Otherwise go to EXEC.
- EXEC, R-type/ADDI: go to WB.
- EXEC, LW/SW: alu_op=ADD, alu_src_b=2; go to MEM.
- EXEC, BEQ/BNE: alu_op=SUB, alu_src_b=0. pc_write=1 and pc_src=1 iff (zero ^ BNE); go to FETCH.
- EXEC, J: pc_write=1, pc_src=2; go to FETCH.
- EXEC, JAL: reg_write=1, wb_src=2, pc_write=1, pc_src=2; go to FETCH.
- MEM: mem_req=1, iord=1, mem_we=SW. On mem_ready: SW goes to FETCH, LW goes to WB.
- WB: reg_write=1. wb_src=1 for LW, else 0. reg_dst=1 for LW/ADDI, 0 for R-type. Go to FETCH.
- icount: increments by 1 on every transition into FETCH from EXEC/MEM/WB, and on HALT entry via the HALT opcode. It wraps at 2**ICNT_W.
- Handshake:
  - mem_req stays asserted, with address select and mem_we stable, until the cycle mem_ready=1; it may deassert the next cycle.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready in the same cycle mem_req first rises is a valid zero-wait completion.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0.
  - At all-ones: set bus_error, drop mem_req, go to HALT.
  - mem_ready in the same cycle the count reaches all-ones wins; no error is raised.
- HALT: halted=1 and all strobes are 0. HALT exits only via reset.
- Reset mid-operation, including during a pending mem_req: mem_req drops the next cycle and the state returns to FETCH. illegal, bus_error and icount clear.
- Cycle counts with zero-wait memory:
  - R-type/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - Branch/J/JAL: 3.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - State encoding localparams: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - Opcode constants.
  - ALU op codes: ADD=000, SUB=001, plus the func encodings.
  - pc_src, wb_src and alu_src_b select constants.
- One sub-module, mem_handshake_timer: mem_req hold plus timeout counter, reporting done/timeout to the FSM.

Test Plan:
- Reset: reset held 3 cycles, then released -> all outputs 0 during reset; mem_req=1 the first cycle after release; icount=0.
- ADDI with zero-wait memory: opcode=00010, mem_ready tied high -> states FETCH, DECODE, EXEC, WB in 4 cycles. WB cycle has reg_write=1, reg_dst=1, wb_src=0. icount=1.
- LW with waits: mem_ready low for 3 cycles in FETCH and 2 cycles in MEM -> mem_req and iord stable while waiting; WB has wb_src=1; 10 cycles total.
- Branches: BEQ with zero=1 -> pc_write with pc_src=1 in EXEC. BNE with zero=1 -> pc_write stays 0 in EXEC. Next state FETCH in both cases.
- Timeout: mem_ready held 0 in MEM for 15 cycles -> bus_error=1, halted=1, mem_req=0 the next cycle. Same case with mem_ready on wait cycle 15 -> no error.
- Illegal then reset: opcode=01010 -> illegal=1, HALT. Reset asserted mid-FETCH with mem_req=1 -> all flags clear and fetch restarts.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control sequencer: states, opcodes,
// ALU functions and datapath mux selects.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [4:0] OP_LW   = 5'b00000;
  localparam logic [4:0] OP_SW   = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_BEQ  = 5'b00011;
  localparam logic [4:0] OP_BNE  = 5'b00100;
  localparam logic [4:0] OP_J    = 5'b00101;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b00111;

  // R-type instructions pass func straight through, so ADD/SUB share the func encoding.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC  = 2'd2;

  localparam logic [1:0] SRC_B_REG = 2'd0;
  localparam logic [1:0] SRC_B_ONE = 2'd1;
  localparam logic [1:0] SRC_B_IMM = 2'd2;

  function automatic logic op_is_illegal(input logic [4:0] op);
    return !op[4] && op[3];
  endfunction

endpackage

// File: rtl/mem_handshake_timer.sv
// Memory request hold and wait-cycle watchdog; reports completion or timeout
// of the request currently presented by the sequencer.
module mem_handshake_timer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic request,
  input  logic mem_ready,
  output logic mem_req,
  output logic done,
  output logic timeout
);

  // The last wait cycle is the one that would push the count to all-ones.
  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] wait_cnt_reg;

  assign mem_req = request;
  assign done    = request && mem_ready;
  assign timeout = request && !mem_ready && (wait_cnt_reg == LAST_WAIT);

  // Idle or completing cycles clear the count, so every new request starts at zero.
  always_ff @(posedge clk) begin
    if (reset || !request || mem_ready) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + TIMEOUT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the 16-bit core: one datapath phase per
// state, memory handshake with timeout, sticky error flags, retired count.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter int ICNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        opcode,
  input  logic [2:0]        func,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              iord,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [2:0]        alu_op,
  output logic [1:0]        alu_src_b,
  output logic              reg_write,
  output logic [1:0]        wb_src,
  output logic              reg_dst,
  output logic              halted,
  output logic              illegal,
  output logic              bus_error,
  output logic [ICNT_W-1:0] icount
);

  state_t             state_reg;
  logic               started_reg;
  logic [4:0]         opcode_reg;
  logic [2:0]         func_reg;
  logic               illegal_reg;
  logic               bus_error_reg;
  logic [ICNT_W-1:0]  icount_reg;

  logic request, done, timeout;
  logic is_rtype, is_lw, is_sw, is_addi, is_beq, is_bne, is_jal;

  assign is_rtype = opcode_reg[4];
  assign is_lw    = (opcode_reg == OP_LW);
  assign is_sw    = (opcode_reg == OP_SW);
  assign is_addi  = (opcode_reg == OP_ADDI);
  assign is_beq   = (opcode_reg == OP_BEQ);
  assign is_bne   = (opcode_reg == OP_BNE);
  assign is_jal   = (opcode_reg == OP_JAL);

  // started_reg keeps every output low through reset and the release cycle.
  assign request = started_reg && ((state_reg == FETCH) || (state_reg == MEM));

  mem_handshake_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .request   (request),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .done      (done),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      started_reg   <= 1'b0;
      opcode_reg    <= '0;
      func_reg      <= '0;
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
      icount_reg    <= '0;
    end else begin
      started_reg <= 1'b1;
      case (state_reg)
        FETCH: begin
          if (timeout) begin
            bus_error_reg <= 1'b1;
            state_reg     <= HALT;
          end else if (done) begin
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          opcode_reg <= opcode;
          func_reg   <= func;
          if (op_is_illegal(opcode)) begin
            illegal_reg <= 1'b1;
            state_reg   <= HALT;
          end else if (opcode == OP_HALT) begin
            icount_reg <= icount_reg + ICNT_W'(1);
            state_reg  <= HALT;
          end else begin
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          if (is_lw || is_sw) begin
            state_reg <= MEM;
          end else if (is_rtype || is_addi) begin
            state_reg <= WB;
          end else begin
            icount_reg <= icount_reg + ICNT_W'(1);
            state_reg  <= FETCH;
          end
        end
        MEM: begin
          if (timeout) begin
            bus_error_reg <= 1'b1;
            state_reg     <= HALT;
          end else if (done) begin
            if (is_sw) begin
              icount_reg <= icount_reg + ICNT_W'(1);
              state_reg  <= FETCH;
            end else begin
              state_reg <= WB;
            end
          end
        end
        WB: begin
          icount_reg <= icount_reg + ICNT_W'(1);
          state_reg  <= FETCH;
        end
        HALT:    state_reg <= HALT;
        default: state_reg <= FETCH;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_SEQ;
    alu_op    = ALU_ADD;
    alu_src_b = SRC_B_REG;
    reg_write = 1'b0;
    wb_src    = WB_SRC_ALU;
    reg_dst   = 1'b0;
    halted    = 1'b0;
    if (started_reg) begin
      case (state_reg)
        FETCH: begin
          alu_src_b = SRC_B_ONE;
          ir_write  = done;
          pc_write  = done;
        end
        EXEC: begin
          if (is_rtype) begin
            alu_op = func_reg;
          end else if (is_addi || is_lw || is_sw) begin
            alu_src_b = SRC_B_IMM;
          end else if (is_beq || is_bne) begin
            alu_op   = ALU_SUB;
            pc_write = zero ^ is_bne;
            pc_src   = (zero ^ is_bne) ? PC_SRC_BR : PC_SRC_SEQ;
          end else begin
            pc_write  = 1'b1;
            pc_src    = PC_SRC_JMP;
            reg_write = is_jal;
            wb_src    = is_jal ? WB_SRC_PC : WB_SRC_ALU;
          end
        end
        MEM: begin
          iord   = 1'b1;
          mem_we = is_sw;
        end
        WB: begin
          reg_write = 1'b1;
          wb_src    = is_lw ? WB_SRC_MEM : WB_SRC_ALU;
          reg_dst   = is_lw || is_addi;
        end
        HALT:    halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  assign illegal   = illegal_reg;
  assign bus_error = bus_error_reg;
  assign icount    = icount_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench: a per-instruction cycle planner builds the expected output stream
// from the instruction semantics; the stream is replayed and compared each cycle.
module tb_multicycle_control_fsm;

  localparam int TIMEOUT_W  = 4;
  localparam int ICNT_W     = 16;
  localparam int WAIT_LIMIT = (1 << TIMEOUT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [4:0]        opcode = '0;
  logic [2:0]        func = '0;
  logic              zero = 1'b0;
  logic              mem_ready = 1'b0;
  logic              mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]        pc_src, alu_src_b, wb_src;
  logic [2:0]        alu_op;
  logic              reg_write, reg_dst, halted, illegal, bus_error;
  logic [ICNT_W-1:0] icount;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.TIMEOUT_W(TIMEOUT_W), .ICNT_W(ICNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_src(wb_src),
    .reg_dst(reg_dst), .halted(halted), .illegal(illegal),
    .bus_error(bus_error), .icount(icount)
  );

  typedef struct packed {
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [1:0]  alu_src_b;
    logic        reg_write;
    logic [1:0]  wb_src;
    logic        reg_dst, halted, illegal, bus_error;
    logic [15:0] icount;
  } outs_t;

  typedef struct packed {
    logic       chk;
    logic       rst;
    logic [4:0] op;
    logic [2:0] fn;
    logic       z;
    logic       rdy;
    outs_t      exp;
  } cyc_t;

  cyc_t        plan[$];
  cyc_t        cur;
  logic        cur_valid = 1'b0;
  int          cyc_no = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        m_illegal = 1'b0;
  logic        m_bus_error = 1'b0;
  logic [15:0] m_icount = '0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic outs_t base();
    outs_t e;
    e = '0;
    e.illegal   = m_illegal;
    e.bus_error = m_bus_error;
    e.icount    = m_icount;
    return e;
  endfunction

  function automatic logic [4:0] rop();
    return 5'($urandom);
  endfunction

  function automatic logic [2:0] rfn();
    return 3'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic push(input logic chk, input logic rst, input logic [4:0] op, input logic [2:0] fn,
                      input logic z, input logic rdy, input outs_t e);
    cyc_t c;
    c.chk = chk; c.rst = rst; c.op = op; c.fn = fn; c.z = z; c.rdy = rdy; c.exp = e;
    plan.push_back(c);
  endtask

  // Memory access that completes after w wait cycles, or times out after WAIT_LIMIT.
  task automatic mem_phase(input bit is_mem, input bit we, input int w, output bit ok);
    outs_t e;
    for (int i = 0; i < WAIT_LIMIT; i++) begin
      e = base();
      e.mem_req = 1'b1;
      e.iord    = is_mem;
      e.mem_we  = we;
      if (!is_mem) e.alu_src_b = 2'd1;
      if (i == w) begin
        if (!is_mem) begin
          e.ir_write = 1'b1;
          e.pc_write = 1'b1;
        end
        push(1'b1, 1'b0, rop(), rfn(), rbit(), 1'b1, e);
        ok = 1'b1;
        return;
      end
      push(1'b1, 1'b0, rop(), rfn(), rbit(), 1'b0, e);
    end
    m_bus_error = 1'b1;
    ok = 1'b0;
  endtask

  task automatic halt_cycles(input int n);
    outs_t e;
    e = base();
    e.halted = 1'b1;
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, rop(), rfn(), rbit(), rbit(), e);
  endtask

  // First reset cycle still shows the interrupted phase, so it is not compared.
  task automatic reset_seq(input int n);
    push(1'b0, 1'b1, rop(), rfn(), rbit(), rbit(), base());
    m_illegal = 1'b0;
    m_bus_error = 1'b0;
    m_icount = '0;
    for (int i = 1; i < n; i++) push(1'b1, 1'b1, rop(), rfn(), rbit(), rbit(), '0);
    push(1'b1, 1'b0, rop(), rfn(), rbit(), rbit(), '0);
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [2:0] fn, input logic z,
                           input int fw, input int mw, output int ncyc, output bit stopped);
    int    start;
    bit    ok;
    bit    rtype, lw, sw, addi, bne, jal, taken;
    outs_t e;
    start = plan.size();
    stopped = 1'b0;
    rtype = op[4]; lw = (op == 5'd0); sw = (op == 5'd1); addi = (op == 5'd2);
    bne = (op == 5'd4); jal = (op == 5'd6);
    mem_phase(1'b0, 1'b0, fw, ok);
    if (!ok) begin
      stopped = 1'b1; halt_cycles(3); ncyc = plan.size() - start; return;
    end
    push(1'b1, 1'b0, op, fn, rbit(), rbit(), base());
    if (!op[4] && op[3]) begin
      m_illegal = 1'b1;
      stopped = 1'b1; halt_cycles(3); ncyc = plan.size() - start; return;
    end
    if (op == 5'd7) begin
      m_icount++;
      stopped = 1'b1; halt_cycles(3); ncyc = plan.size() - start; return;
    end
    e = base();
    if (rtype) begin
      e.alu_op = fn;
    end else if (addi || lw || sw) begin
      e.alu_src_b = 2'd2;
    end else if (op == 5'd3 || bne) begin
      taken = z ^ bne;
      e.alu_op = 3'd1;
      e.pc_write = taken;
      e.pc_src = taken ? 2'd1 : 2'd0;
    end else begin
      e.pc_write = 1'b1;
      e.pc_src = 2'd2;
      if (jal) begin
        e.reg_write = 1'b1;
        e.wb_src = 2'd2;
      end
    end
    // Live opcode/func are scrambled after decode: execution must use the latched copy.
    push(1'b1, 1'b0, rop(), rfn(), z, rbit(), e);
    if (!(rtype || addi || lw || sw)) begin
      m_icount++; ncyc = plan.size() - start; return;
    end
    if (lw || sw) begin
      mem_phase(1'b1, sw, mw, ok);
      if (!ok) begin
        stopped = 1'b1; halt_cycles(3); ncyc = plan.size() - start; return;
      end
      if (sw) begin
        m_icount++; ncyc = plan.size() - start; return;
      end
    end
    e = base();
    e.reg_write = 1'b1;
    e.wb_src = lw ? 2'd1 : 2'd0;
    e.reg_dst = lw || addi;
    push(1'b1, 1'b0, rop(), rfn(), rbit(), rbit(), e);
    m_icount++;
    ncyc = plan.size() - start;
  endtask

  function automatic int pick_wait();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 8) return $urandom_range(0, 3);
    return $urandom_range(13, 15);
  endfunction

  always @(negedge clk) begin
    if (cur_valid && cur.chk) begin
      check("mem_req",   cyc_no, 32'(mem_req),   32'(cur.exp.mem_req));
      check("mem_we",    cyc_no, 32'(mem_we),    32'(cur.exp.mem_we));
      check("iord",      cyc_no, 32'(iord),      32'(cur.exp.iord));
      check("ir_write",  cyc_no, 32'(ir_write),  32'(cur.exp.ir_write));
      check("pc_write",  cyc_no, 32'(pc_write),  32'(cur.exp.pc_write));
      check("pc_src",    cyc_no, 32'(pc_src),    32'(cur.exp.pc_src));
      check("alu_op",    cyc_no, 32'(alu_op),    32'(cur.exp.alu_op));
      check("alu_src_b", cyc_no, 32'(alu_src_b), 32'(cur.exp.alu_src_b));
      check("reg_write", cyc_no, 32'(reg_write), 32'(cur.exp.reg_write));
      check("wb_src",    cyc_no, 32'(wb_src),    32'(cur.exp.wb_src));
      check("reg_dst",   cyc_no, 32'(reg_dst),   32'(cur.exp.reg_dst));
      check("halted",    cyc_no, 32'(halted),    32'(cur.exp.halted));
      check("illegal",   cyc_no, 32'(illegal),   32'(cur.exp.illegal));
      check("bus_error", cyc_no, 32'(bus_error), 32'(cur.exp.bus_error));
      check("icount",    cyc_no, 32'(icount),    32'(cur.exp.icount));
    end
  end

  initial begin
    int         n;
    bit         stp;
    logic [4:0] op;
    int         sel;

    reset_seq(3);
    run_instr(5'd2, 3'd0, 1'b0, 0, 0, n, stp);
    check("addi_cycles", -1, 32'(n), 32'd4);
    check("addi_icount", -1, 32'(m_icount), 32'd1);
    run_instr(5'd0, 3'd0, 1'b0, 3, 2, n, stp);
    check("lw_wait_cycles", -1, 32'(n), 32'd10);
    run_instr(5'd0, 3'd0, 1'b0, 0, 0, n, stp);
    check("lw_cycles", -1, 32'(n), 32'd5);
    run_instr(5'd1, 3'd0, 1'b0, 0, 0, n, stp);
    check("sw_cycles", -1, 32'(n), 32'd4);
    run_instr(5'd3, 3'd0, 1'b1, 0, 0, n, stp);
    check("beq_cycles", -1, 32'(n), 32'd3);
    run_instr(5'd4, 3'd0, 1'b1, 0, 0, n, stp);
    check("bne_cycles", -1, 32'(n), 32'd3);
    run_instr(5'd6, 3'd0, 1'b0, 0, 0, n, stp);
    check("jal_cycles", -1, 32'(n), 32'd3);
    run_instr(5'b10110, 3'd5, 1'b0, 0, 0, n, stp);
    check("rtype_cycles", -1, 32'(n), 32'd4);
    check("icount_after_seq", -1, 32'(m_icount), 32'd8);
    run_instr(5'd0, 3'd0, 1'b0, 0, 14, n, stp);
    check("lw_ready_on_last_wait", -1, 32'(m_bus_error), 32'd0);
    check("lw_last_wait_cycles", -1, 32'(n), 32'd19);
    run_instr(5'd0, 3'd0, 1'b0, 0, 15, n, stp);
    check("lw_timeout_flag", -1, 32'(m_bus_error), 32'd1);
    reset_seq(2);
    run_instr(5'b01010, 3'd0, 1'b0, 0, 0, n, stp);
    check("illegal_flag", -1, 32'(m_illegal), 32'd1);
    reset_seq(2);
    run_instr(5'd5, 3'd0, 1'b0, 0, 0, n, stp);
    for (int i = 0; i < 3; i++) begin
      outs_t e;
      e = base(); e.mem_req = 1'b1; e.alu_src_b = 2'd1;
      push(1'b1, 1'b0, rop(), rfn(), rbit(), 1'b0, e);
    end
    reset_seq(2);

    for (int k = 0; k < 250; k++) begin
      sel = $urandom_range(0, 19);
      if (sel < 14)      op = 5'($urandom_range(0, 6));
      else if (sel < 18) op = {1'b1, 4'($urandom)};
      else if (sel == 18) op = 5'd7;
      else               op = {2'b01, 3'($urandom)};
      run_instr(op, rfn(), rbit(), pick_wait(), pick_wait(), n, stp);
      if (stp) reset_seq($urandom_range(1, 3));
    end

    foreach (plan[k]) begin
      @(posedge clk);
      #1;
      reset     = plan[k].rst;
      opcode    = plan[k].op;
      func      = plan[k].fn;
      zero      = plan[k].z;
      mem_ready = plan[k].rdy;
      cur       = plan[k];
      cyc_no    = k;
      cur_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    cur_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
